// File: rtl/hazard_forward_ctrl.sv
// Stall and operand-forward select generator for a 5-stage MIPS pipeline.
// Keeps shadow E/M/W destination records plus a mult/div busy counter.
module hazard_forward_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] dst_d,
  input  logic [1:0] tnew_d,
  input  logic       link_d,
  input  logic       md_start_d,
  input  logic       md_div_d,
  input  logic       md_use_d,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fw_rs_d_src,
  output logic [1:0] fw_rt_d_src,
  output logic [1:0] fw_rs_e_src,
  output logic [1:0] fw_rt_e_src,
  output logic       md_busy
);

  localparam int unsigned RW = 5;
  localparam int unsigned TW = 2;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic [TW-1:0] tnew;
    logic          link;
    logic          md_start;
    logic          md_div;
  } e_rec_t;

  typedef struct packed {
    logic [RW-1:0] dst;
    logic [TW-1:0] tnew;
    logic          link;
  } m_rec_t;

  e_rec_t        e_q, e_d;
  m_rec_t        m_q, m_d;
  logic [RW-1:0] w_dst_q, w_dst_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  logic data_stall;
  logic md_stall;

  // Consumer at idx needs a value that an E or M producer has not finished yet.
  function automatic logic pending(input logic [RW-1:0] idx, input logic [TW-1:0] tuse,
                                   input e_rec_t e, input m_rec_t m);
    pending = 1'b0;
    if (idx != '0 && tuse != 2'd3) begin
      pending = (e.dst == idx && e.tnew > tuse) || (m.dst == idx && m.tnew > tuse);
    end
  endfunction

  // Forward source for idx: finished M result beats W write data.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] idx, input m_rec_t m,
                                         input logic [RW-1:0] w_dst);
    fwd_sel = 2'd0;
    if (idx != '0 && m.dst == idx && m.tnew == '0) begin
      fwd_sel = m.link ? 2'd2 : 2'd1;
    end else if (idx != '0 && w_dst == idx) begin
      fwd_sel = 2'd3;
    end
  endfunction

  always_comb begin
    md_busy     = (md_cnt_q != '0);
    data_stall  = pending(rs_d, tuse_rs_d, e_q, m_q) | pending(rt_d, tuse_rt_d, e_q, m_q);
    md_stall    = (md_start_d | md_use_d) & (md_busy | e_q.md_start);
    stall       = data_stall | md_stall;
    fw_rs_d_src = fwd_sel(rs_d, m_q, w_dst_q);
    fw_rt_d_src = fwd_sel(rt_d, m_q, w_dst_q);
    fw_rs_e_src = fwd_sel(e_q.rs, m_q, w_dst_q);
    fw_rt_e_src = fwd_sel(e_q.rt, m_q, w_dst_q);
  end

  // Record advance; a stall inserts a bubble into E, a flush empties E/M/W.
  always_comb begin
    e_d      = '0;
    m_d      = '0;
    w_dst_d  = m_q.dst;
    md_cnt_d = md_cnt_q;

    m_d.dst  = e_q.dst;
    m_d.link = e_q.link;
    m_d.tnew = (e_q.tnew == '0) ? '0 : TW'(e_q.tnew - TW'(1));

    if (!stall) begin
      e_d.rs       = rs_d;
      e_d.rt       = rt_d;
      e_d.dst      = dst_d;
      e_d.tnew     = tnew_d;
      e_d.link     = link_d;
      e_d.md_start = md_start_d;
      e_d.md_div   = md_div_d;
    end

    if (flush) begin
      e_d     = '0;
      m_d     = '0;
      w_dst_d = '0;
    end

    // Busy counter survives flush; an md op in E only starts if not flushed.
    if (e_q.md_start && !flush) begin
      md_cnt_d = e_q.md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q      <= '0;
      m_q      <= '0;
      w_dst_q  <= '0;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_dst_q  <= w_dst_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed hazard scenarios plus
// random traffic against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs_d = '0, rt_d = '0, dst_d = '0;
  logic [1:0] tuse_rs_d = 2'd3, tuse_rt_d = 2'd3, tnew_d = '0;
  logic       link_d = 1'b0, md_start_d = 1'b0, md_div_d = 1'b0, md_use_d = 1'b0, flush = 1'b0;
  logic       stall, md_busy;
  logic [1:0] fw_rs_d_src, fw_rt_d_src, fw_rs_e_src, fw_rt_e_src;

  hazard_forward_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d),
    .dst_d(dst_d), .tnew_d(tnew_d), .link_d(link_d),
    .md_start_d(md_start_d), .md_div_d(md_div_d), .md_use_d(md_use_d), .flush(flush),
    .stall(stall), .fw_rs_d_src(fw_rs_d_src), .fw_rt_d_src(fw_rt_d_src),
    .fw_rs_e_src(fw_rs_e_src), .fw_rt_e_src(fw_rt_e_src), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Model: whole instructions sitting in E/M/W; remaining latency derived from stage depth.
  typedef struct {
    int rs, rt, dst, tnew, link, md_start, md_div;
  } ins_t;

  ins_t ins_e, ins_m, ins_w, nop;
  int   cyc = 0;
  int   busy_until = -1;
  int   checks = 0;
  int   errors = 0;

  function automatic int remaining(input ins_t i, input int depth);
    return (i.tnew - depth > 0) ? i.tnew - depth : 0;
  endfunction

  function automatic bit exp_busy();
    return cyc <= busy_until;
  endfunction

  function automatic bit waits_on(input int idx, input int tuse);
    if (idx == 0 || tuse == 3) return 1'b0;
    return (ins_e.dst == idx && remaining(ins_e, 0) > tuse) ||
           (ins_m.dst == idx && remaining(ins_m, 1) > tuse);
  endfunction

  function automatic bit exp_stall();
    bit md_req;
    md_req = (md_start_d || md_use_d) && (exp_busy() || ins_e.md_start != 0);
    return waits_on(int'(rs_d), int'(tuse_rs_d)) || waits_on(int'(rt_d), int'(tuse_rt_d)) || md_req;
  endfunction

  function automatic int exp_fw(input int idx);
    if (idx == 0) return 0;
    if (ins_m.dst == idx && remaining(ins_m, 1) == 0) return (ins_m.link != 0) ? 2 : 1;
    if (ins_w.dst == idx) return 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_model();
    chk("stall", int'(stall), int'(exp_stall()));
    chk("fw_rs_d", int'(fw_rs_d_src), exp_fw(int'(rs_d)));
    chk("fw_rt_d", int'(fw_rt_d_src), exp_fw(int'(rt_d)));
    chk("fw_rs_e", int'(fw_rs_e_src), exp_fw(ins_e.rs));
    chk("fw_rt_e", int'(fw_rt_e_src), exp_fw(ins_e.rt));
    chk("md_busy", int'(md_busy), int'(exp_busy()));
  endtask

  task automatic drive(input int rs, input int rt, input int tus, input int tut,
                       input int dst, input int tnew, input int link,
                       input int mds, input int mdd, input int mdu, input int fl);
    @(negedge clk);
    rs_d = 5'(rs); rt_d = 5'(rt); tuse_rs_d = 2'(tus); tuse_rt_d = 2'(tut);
    dst_d = 5'(dst); tnew_d = 2'(tnew); link_d = 1'(link);
    md_start_d = 1'(mds); md_div_d = 1'(mdd); md_use_d = 1'(mdu); flush = 1'(fl);
    #1;
    check_model();
  endtask

  task automatic nop_step();
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit   st;
    ins_t d_ins;
    st = exp_stall();
    d_ins = '{rs: int'(rs_d), rt: int'(rt_d), dst: int'(dst_d), tnew: int'(tnew_d),
              link: int'(link_d), md_start: int'(md_start_d), md_div: int'(md_div_d)};
    @(posedge clk);
    if (!flush && ins_e.md_start != 0) busy_until = cyc + ((ins_e.md_div != 0) ? DIV_N : MULT_N);
    cyc++;
    if (flush) begin
      ins_w = nop; ins_m = nop; ins_e = nop;
    end else begin
      ins_w = ins_m; ins_m = ins_e; ins_e = st ? nop : d_ins;
    end
  endtask

  task automatic md_wait(input int is_div, input int exp_stalls, input int exp_busy_cycles, input string tag);
    int scnt, bcnt;
    scnt = 0; bcnt = 0;
    drive(0, 0, 3, 3, 0, 0, 0, 1, is_div, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 3, 3, 2, 1, 0, 0, 0, 1, 0);
      if (md_busy) bcnt++;
      if (!stall) break;
      scnt++;
      tick();
    end
    tick();
    chk({tag, "_stalls"}, scnt, exp_stalls);
    chk({tag, "_busy"}, bcnt, exp_busy_cycles);
  endtask

  initial begin
    nop = '{default: 0};
    ins_e = nop; ins_m = nop; ins_w = nop;

    // Reset state
    #12;
    chk("rst_stall", int'(stall), 0);
    chk("rst_busy", int'(md_busy), 0);
    check_model();
    @(negedge clk);
    reset_n = 1'b1;

    // lw $1 ; addu $2,$1,$3 (tuse 1): one stall, then W forward
    drive(0, 0, 3, 3, 1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 3, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    chk("lw_use_stall", int'(stall), 1); tick();
    drive(1, 3, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    chk("lw_use_release", int'(stall), 0); tick();
    nop_step();
    chk("lw_use_fw_e", int'(fw_rs_e_src), 3); tick();
    nop_step(); tick(); nop_step(); tick();

    // addu $1 ; beq $1,$0 (tuse 0): one stall, then M ALU forward to D
    drive(0, 0, 3, 3, 1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_stall", int'(stall), 1); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_release", int'(stall), 0);
    chk("beq_fw_d", int'(fw_rs_d_src), 1); tick();
    nop_step(); tick(); nop_step(); tick();

    // jal ; addu $4,$31,$0: PC+8 forward into E
    drive(0, 0, 3, 3, 31, 0, 1, 0, 0, 0, 0); tick();
    drive(31, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0);
    chk("jal_nostall", int'(stall), 0); tick();
    nop_step();
    chk("jal_fw_e", int'(fw_rs_e_src), 2); tick();
    nop_step(); tick(); nop_step(); tick();

    // Same pattern writing $0: nothing forwards or stalls
    drive(0, 0, 3, 3, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0);
    chk("r0_nostall", int'(stall), 0); tick();
    nop_step();
    chk("r0_fw_rs_e", int'(fw_rs_e_src), 0);
    chk("r0_fw_rt_e", int'(fw_rt_e_src), 0); tick();
    nop_step(); tick(); nop_step(); tick();

    // lw $5 ; addu $5 ; consumer of $5: M beats W
    drive(0, 0, 3, 3, 5, 2, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 3, 3, 5, 1, 0, 0, 0, 0, 0); tick();
    drive(5, 0, 1, 3, 6, 1, 0, 0, 0, 0, 0); tick();
    nop_step();
    chk("prio_fw_e", int'(fw_rs_e_src), 1); tick();
    nop_step(); tick(); nop_step(); tick();

    // div then mflo; mult then mflo
    md_wait(1, DIV_N + 1, DIV_N, "div");
    md_wait(0, MULT_N + 1, MULT_N, "mult");
    nop_step(); tick(); nop_step(); tick();

    // Flush while lw in E and dependent add in D
    drive(0, 0, 3, 3, 1, 2, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 1, 3, 2, 1, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 1, 3, 2, 1, 0, 0, 0, 0, 0);
    chk("flush_nostall", int'(stall), 0); tick();
    nop_step(); tick(); nop_step(); tick();

    // Reset dropped mid-div
    drive(0, 0, 3, 3, 0, 0, 0, 1, 1, 0, 0); tick();
    nop_step(); tick();
    drive(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
    chk("middiv_busy", int'(md_busy), 1);
    #2 reset_n = 1'b0;
    #1;
    ins_e = nop; ins_m = nop; ins_w = nop; busy_until = -1;
    chk("async_rst_busy", int'(md_busy), 0);
    chk("async_rst_stall", int'(stall), 0);
    check_model();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic on a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 11) == 0), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15) == 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Producer side of the operand-forwarding interface: generates the stall and the 2-bit forward-source selects consumed by the D- and E-stage operand muxes of the 5-stage MIPS pipeline.
- Keeps a shadow pipeline of destination register, Tnew and link flag for E/M/W, plus a mult/div busy counter.
- Sits beside the pipeline registers; driven by D-stage decode fields.

Parameters:
- MULT_CYCLES, 5, busy cycles loaded on mult/multu start
- DIV_CYCLES, 10, busy cycles loaded on div/divu start

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- rs_d  in  5  D-stage rs index
- rt_d  in  5  D-stage rt index
- tuse_rs_d  in  2  cycles until rs is needed (0=D, 1=E, 2=M, 3=unused)
- tuse_rt_d  in  2  same encoding, for rt
- dst_d  in  5  D-stage write register (0 = none)
- tnew_d  in  2  producer latency from E (0=link, 1=ALU, 2=load)
- link_d  in  1  result is PC+8 (jal/jalr)
- md_start_d  in  1  D instr is mult/multu/div/divu
- md_div_d  in  1  1=div kind, 0=mult kind
- md_use_d  in  1  D instr is mfhi/mflo/mthi/mtlo
- flush  in  1  exception/eret flush of E/M/W
- stall  out  1  hold PC/F/D, bubble E
- fw_rs_d_src  out  2  0=RF, 1=M ALU out, 2=M PC+8, 3=W write data
- fw_rt_d_src  out  2  same encoding
- fw_rs_e_src  out  2  0=RS_E reg, 1=M ALU out, 2=M PC+8, 3=W write data
- fw_rt_e_src  out  2  same encoding
- md_busy  out  1  mult/div unit busy

Behaviour:
- Internal registers:
  - E record {rs,rt,dst,tnew,link,md_start,md_div}; M record {dst,tnew,link}; W record {dst}.
  - 4-bit md counter.
- Reset (async, reset_n=0): all records zero, counter 0.
  - Hence stall=0, md_busy=0, all selects=0.
- Each rising clk edge:
  - W<=M.
  - M.dst/link<=E.dst/link; M.tnew<=(E.tnew==0)?0:E.tnew-1.
  - E<=D fields if stall=0; else E zeroed (bubble).
- Flush=1: E, M, W records all zeroed at that edge and E does not load D. The D instruction is refetched upstream.
- Flush has priority over stall and over an md start in E.
- md counter:
  - If the E record has md_start=1 and flush=0, load MULT_CYCLES or DIV_CYCLES per md_div.
  - Otherwise, if nonzero, decrement.
  - md_busy = (counter!=0).
  - Counter is not cleared by flush.
- stall (combinational) = data_stall | md_stall.
  - data_stall for rs: rs_d!=0 and tuse_rs_d!=3 and either condition holds:
    - E.dst==rs_d and E.tnew>tuse_rs_d
    - M.dst==rs_d and M.tnew>tuse_rs_d
  - rt uses the same rule.
  - md_stall = (md_start_d|md_use_d) & (md_busy | E.md_start).
- E forwarding, combinational, for rs (rt identical):
  - If E.rs!=0, M.dst==E.rs and M.tnew==0, then select = M.link?2:1.
  - Else if E.rs!=0 and W.dst==E.rs, select = 3.
  - Else select = 0.
  - M has priority over W.
- D forwarding: same rule using rs_d/rt_d against M and W.
  - E-stage producers are never forwarded to D; a pending E producer with tnew>tuse causes a stall instead.
- Register 0 never forwards or stalls.
- Selects are valid even when stall=1; the consumer mux ignores them for bubbled stages.
- Latency: outputs are combinational from current records and D inputs; records update one cycle later.

Test Plan:
- lw $1 then addu $2,$1,$3 (tuse 1):
  - Required: stall=1 for exactly 1 cycle.
  - Next cycle: fw_rs_e_src=3 (W write data).
- addu $1 then beq $1,$0 (tuse 0):
  - Required: stall=1 one cycle (E producer, tnew 1>0).
  - Then fw_rs_d_src=1.
- jal then addu $4,$31,$0 in E:
  - Required: fw_rs_e_src=2 when jal is in M.
  - Same pattern with $0 as the destination: all selects 0, no stall.
- Back-to-back writers of $5:
  - Order: ALU write in M, load write in W; consumer in E reads $5.
  - Required: fw_rs_e_src=1 (M priority).
- div in E followed by mflo in D:
  - Required: stall held until counter reaches 0, i.e. DIV_CYCLES+1 stall cycles total (1 for E.md_start, 10 busy); md_busy high 10 cycles.
  - Mult variant: 6 cycles.
- Flush and reset:
  - Flush asserted while lw in E and dependent add in D: no stall next cycle; records clear.
  - reset_n dropped mid-div: md_busy=0 immediately (async), all outputs 0.
